alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
Initiator side of the ALU operation interface (ALUCon/DataA/DataB -> Result). Accepts one decoded-instruction request at a time via valid/ready, maps MIPS opcode/funct to a 3-bit ALUCon, and drives operands to the combinational ALU. Holds ALUCon and operands stable for a per-operation settle time, captures Result, and presents it to writeback via valid/ready. Sits between the decode stage and the ALU in the multi-cycle datapath.

Parameters:
MULDIV_WAIT, 4, settle cycles for multiply/divide (>=1).
SLT_UNSIGNED, 0, reserved; must be 0 (signed slt not supported; ALU compare is unsigned).

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
InstrValid  input  1  request valid
InstrReady  output  1  request accepted when InstrValid&&InstrReady
Opcode  input  6  instruction [31:26]
Funct  input  6  instruction [5:0]
RsData  input  32  register rs value
RtData  input  32  register rt value
Imm  input  16  instruction [15:0]
ALUCon  output  3  ALU op: 000 add, 001 sub, 010 mul, 011 div, 100 slt
DataA  output  32  ALU operand A
DataB  output  32  ALU operand B
ALUResult  input  32  ALU Result
ResValid  output  1  result valid
ResReady  input  1  writeback accepts when ResValid&&ResReady
Result  output  32  captured result
ResErr  output  1  illegal op (or div-by-zero, see feature); valid with ResValid
Busy  output  1  high in any state except IDLE

Behaviour:
- Reset (async assert, sync release): state IDLE; InstrReady=1, ALUCon=000, DataA=0, DataB=0, ResValid=0, Result=0, ResErr=0, Busy=0, wait counter=0.
- Decode at accept:
  - Opcode 000000, Funct 100000 add -> 000, A=Rs, B=Rt.
  - Funct 100010 sub -> 001.
  - Funct 011000 mult -> 010.
  - Funct 011010 div -> 011.
  - Funct 101010 slt -> 100.
  - Opcode 001000 addi -> 000, B=sign-extended Imm.
  - Opcode 001010 slti -> 100, B=sign-extended Imm.
  - Anything else illegal.
- FSM IDLE -> EXEC -> (WAIT) -> DONE -> IDLE:
  - IDLE: InstrReady=1. On accept, register ALUCon/DataA/DataB; legal -> EXEC; illegal -> DONE directly with Result=0, ResErr=1, ALUCon/DataA/DataB unchanged.
  - EXEC (1 cycle): add/sub/slt capture Result<=ALUResult at end of cycle -> DONE. mul/div load counter=MULDIV_WAIT-1 -> WAIT (if MULDIV_WAIT==1, capture here -> DONE).
  - WAIT: counter decrements each cycle; at counter==0 capture ALUResult -> DONE.
  - DONE: ResValid=1, Result/ResErr stable until ResReady; on handshake ResValid<=0 next cycle, ResErr<=0, -> IDLE.
- Accept-to-ResValid latency: 2 cycles add/sub/slt; 1+MULDIV_WAIT+1 mul/div; 1 illegal.
- InstrReady=0 outside IDLE; no back-to-back accept (next accept earliest the cycle after DONE handshake).
- ALUCon/DataA/DataB held constant from accept until the next accept (never glitch during EXEC/WAIT).
- Result is the low 32 bits of ALU output; mul overflow ignored.
- ResReady held low: DONE held indefinitely, outputs frozen.
- rst_n asserted in any state: immediate return to reset values; in-flight op discarded, no ResValid.

Optional Feature:
DIVZERO_CHK_EN: when defined, div with RtData==0 is flagged at accept: skip EXEC/WAIT, go to DONE with Result=32'hFFFFFFFF, ResErr=1 (latency 1). When undefined, div-by-zero goes through the ALU like any div; Result=ALUResult after settle, ResErr=0.

Test Plan:
- Reset mid-WAIT of mult -> all outputs return to reset values immediately; InstrReady=1.
- add Rs=5,Rt=7 with ResReady=1 -> ALUCon=000, ResValid 2 cycles after accept, Result=12, ResErr=0.
- addi Rs=10,Imm=16'hFFFD -> DataB=32'hFFFFFFFD, Result=7; slti Rs=3,Imm=5 -> ALUCon=100, Result=1.
- mult Rs=6,Rt=7, MULDIV_WAIT=4, ResReady low 3 cycles -> ResValid 6 cycles after accept; Result=42 held stable; InstrReady=0 until handshake.
- Opcode 000000,Funct 100101 (or) -> ResValid 1 cycle after accept, Result=0, ResErr=1, ALUCon unchanged.
- div Rs=9,Rt=0 -> with DIVZERO_CHK_EN: Result=FFFFFFFF, ResErr=1, latency 1; without: ALUCon=011, ResErr=0, latency 6.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_ctrl
// Purpose  : Initiator side of the ALU operation interface. Accepts one
//            decoded instruction via valid/ready, maps opcode/funct to ALUCon,
//            holds operands stable for the operation settle time, captures
//            the ALU result and presents it to writeback via valid/ready.
// Options  : `define DIVZERO_CHK_EN to flag div-by-zero at accept
//            (Result=FFFFFFFF, ResErr=1, no trip through the ALU).
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl #(
  parameter int MULDIV_WAIT  = 4,   // settle cycles for mul/div, >= 1
  parameter int SLT_UNSIGNED = 0    // reserved, must be 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        InstrValid,
  output logic        InstrReady,
  input  logic [5:0]  Opcode,
  input  logic [5:0]  Funct,
  input  logic [31:0] RsData,
  input  logic [31:0] RtData,
  input  logic [15:0] Imm,
  output logic [2:0]  ALUCon,
  output logic [31:0] DataA,
  output logic [31:0] DataB,
  input  logic [31:0] ALUResult,
  output logic        ResValid,
  input  logic        ResReady,
  output logic [31:0] Result,
  output logic        ResErr,
  output logic        Busy
);

  localparam int CNT_W = (MULDIV_WAIT > 1) ? $clog2(MULDIV_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_WAIT - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_SLTI  = 6'b001010;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_MULT = 6'b011000;
  localparam logic [5:0] FN_DIV  = 6'b011010;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  // The ALU only compares unsigned; a signed-slt build has no legal slt.
  localparam logic SLT_OK = (SLT_UNSIGNED == 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        alucon_q, alucon_d;
  logic [31:0]       data_a_q, data_a_d;
  logic [31:0]       data_b_q, data_b_d;
  logic [31:0]       result_q, result_d;
  logic              res_err_q, res_err_d;
  logic              res_valid_q, res_valid_d;

  logic              dec_legal;
  logic [2:0]        dec_con;
  logic              dec_use_imm;
  logic              dec_div_zero;
  logic [31:0]       imm_sext;
  logic              exec_muldiv;

  assign imm_sext = {{16{Imm[15]}}, Imm};

  // Instruction decode: opcode/funct -> ALUCon, operand-B source, legality
  always_comb begin
    dec_legal   = 1'b0;
    dec_con     = OP_ADD;
    dec_use_imm = 1'b0;
    if (Opcode == OPC_RTYPE) begin
      case (Funct)
        FN_ADD:  begin dec_legal = 1'b1;   dec_con = OP_ADD; end
        FN_SUB:  begin dec_legal = 1'b1;   dec_con = OP_SUB; end
        FN_MULT: begin dec_legal = 1'b1;   dec_con = OP_MUL; end
        FN_DIV:  begin dec_legal = 1'b1;   dec_con = OP_DIV; end
        FN_SLT:  begin dec_legal = SLT_OK; dec_con = OP_SLT; end
        default: ;
      endcase
    end else if (Opcode == OPC_ADDI) begin
      dec_legal   = 1'b1;
      dec_con     = OP_ADD;
      dec_use_imm = 1'b1;
    end else if (Opcode == OPC_SLTI) begin
      dec_legal   = SLT_OK;
      dec_con     = OP_SLT;
      dec_use_imm = 1'b1;
    end
  end

`ifdef DIVZERO_CHK_EN
  assign dec_div_zero = dec_legal && (dec_con == OP_DIV) && (RtData == 32'd0);
`else
  assign dec_div_zero = 1'b0;
`endif

  assign exec_muldiv = (alucon_q == OP_MUL) || (alucon_q == OP_DIV);

  // Next-state and datapath register updates; every register holds by default
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alucon_d    = alucon_q;
    data_a_d    = data_a_q;
    data_b_d    = data_b_q;
    result_d    = result_q;
    res_err_d   = res_err_q;
    res_valid_d = res_valid_q;
    case (state_q)
      S_IDLE: begin
        if (InstrValid) begin
          if (!dec_legal) begin
            // ALU-facing outputs stay as they were for an illegal op
            result_d    = 32'd0;
            res_err_d   = 1'b1;
            res_valid_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            alucon_d = dec_con;
            data_a_d = RsData;
            data_b_d = dec_use_imm ? imm_sext : RtData;
            if (dec_div_zero) begin
              result_d    = 32'hFFFF_FFFF;
              res_err_d   = 1'b1;
              res_valid_d = 1'b1;
              state_d     = S_DONE;
            end else begin
              state_d = S_EXEC;
            end
          end
        end
      end
      S_EXEC: begin
        if (exec_muldiv && (MULDIV_WAIT > 1)) begin
          cnt_d   = CNT_LOAD;
          state_d = S_WAIT;
        end else begin
          result_d    = ALUResult;
          res_err_d   = 1'b0;
          res_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          result_d    = ALUResult;
          res_err_d   = 1'b0;
          res_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        if (ResReady) begin
          res_valid_d = 1'b0;
          res_err_d   = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      alucon_q    <= OP_ADD;
      data_a_q    <= 32'd0;
      data_b_q    <= 32'd0;
      result_q    <= 32'd0;
      res_err_q   <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alucon_q    <= alucon_d;
      data_a_q    <= data_a_d;
      data_b_q    <= data_b_d;
      result_q    <= result_d;
      res_err_q   <= res_err_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign InstrReady = (state_q == S_IDLE);
  assign Busy       = (state_q != S_IDLE);
  assign ALUCon     = alucon_q;
  assign DataA      = data_a_q;
  assign DataB      = data_b_q;
  assign Result     = result_q;
  assign ResErr     = res_err_q;
  assign ResValid   = res_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_ctrl
// Purpose  : Self-checking bench for alu_issue_ctrl with a behavioural ALU
//            and an expected-result scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue_ctrl;

  localparam int MW = 4;

  logic        clk;
  logic        rst_n;
  logic        InstrValid;
  logic        InstrReady;
  logic [5:0]  Opcode;
  logic [5:0]  Funct;
  logic [31:0] RsData;
  logic [31:0] RtData;
  logic [15:0] Imm;
  logic [2:0]  ALUCon;
  logic [31:0] DataA;
  logic [31:0] DataB;
  logic [31:0] ALUResult;
  logic        ResValid;
  logic        ResReady;
  logic [31:0] Result;
  logic        ResErr;
  logic        Busy;

  typedef struct {
    logic [31:0] res;
    logic        err;
    logic [2:0]  con;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  alu_issue_ctrl #(.MULDIV_WAIT(MW), .SLT_UNSIGNED(0)) dut (
    .clk(clk), .rst_n(rst_n), .InstrValid(InstrValid), .InstrReady(InstrReady),
    .Opcode(Opcode), .Funct(Funct), .RsData(RsData), .RtData(RtData), .Imm(Imm),
    .ALUCon(ALUCon), .DataA(DataA), .DataB(DataB), .ALUResult(ALUResult),
    .ResValid(ResValid), .ResReady(ResReady), .Result(Result), .ResErr(ResErr),
    .Busy(Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural combinational ALU; div-by-zero returns a recognisable marker
  always_comb begin
    ALUResult = 32'd0;
    case (ALUCon)
      3'b000: ALUResult = DataA + DataB;
      3'b001: ALUResult = DataA - DataB;
      3'b010: ALUResult = DataA * DataB;
      3'b011: ALUResult = (DataB == 32'd0) ? 32'h0BAD_0000 : DataA / DataB;
      3'b100: ALUResult = {31'd0, DataA < DataB};
      default: ALUResult = 32'd0;
    endcase
  end

  // Issue one instruction and wait (bounded) for ResValid; lat counts cycles
  task automatic send(input logic [5:0] op, input logic [5:0] fn,
                      input logic [31:0] rs, input logic [31:0] rt,
                      input logic [15:0] imm, output int lat, output logic rdy);
    @(negedge clk);
    Opcode = op; Funct = fn; RsData = rs; RtData = rt; Imm = imm;
    InstrValid = 1'b1;
    rdy = InstrReady;
    @(posedge clk);
    @(negedge clk);
    InstrValid = 1'b0;
    lat = 1;
    while (ResValid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Hold ResReady low for some cycles, then complete one handshake
  task automatic release_res(input int hold);
    repeat (hold) @(negedge clk);
    ResReady = 1'b1;
    @(posedge clk);
    #1 ResReady = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    total_cnt++;
    if ({InstrReady, ResValid, ResErr, Busy, ALUCon} !== 7'b1000_000) begin
      $display("FAIL reset_ctrl: got %b want 1000000", {InstrReady, ResValid, ResErr, Busy, ALUCon});
    end else pass_cnt++;
    total_cnt++;
    if ({DataA, DataB, Result} !== 96'd0) begin
      $display("FAIL reset_data: got %h/%h/%h want 0", DataA, DataB, Result);
    end else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add;
    int lat; logic rdy; exp_t e;
    sb.push_back('{res: 32'd12, err: 1'b0, con: 3'b000, lat: 2});
    send(6'b000000, 6'b100000, 32'd5, 32'd7, 16'd0, lat, rdy);
    e = sb.pop_front();
    total_cnt++;
    if (rdy !== 1'b1) $display("FAIL add_ready: got %b want 1", rdy); else pass_cnt++;
    total_cnt++;
    if (lat !== e.lat) $display("FAIL add_latency: got %0d want %0d", lat, e.lat); else pass_cnt++;
    total_cnt++;
    if ({Result, ResErr, ALUCon} !== {e.res, e.err, e.con})
      $display("FAIL add_result: got %h/%b/%b want %h/%b/%b", Result, ResErr, ALUCon, e.res, e.err, e.con);
    else pass_cnt++;
    total_cnt++;
    if ({DataA, DataB} !== {32'd5, 32'd7}) $display("FAIL add_operands: got %h/%h want 5/7", DataA, DataB);
    else pass_cnt++;
    release_res(0);
    @(negedge clk);
    total_cnt++;
    if ({ResValid, InstrReady, Busy} !== 3'b010)
      $display("FAIL add_handshake: got %b want 010", {ResValid, InstrReady, Busy});
    else pass_cnt++;
  endtask

  task automatic test_addi_slti;
    logic [5:0]  ops  [2] = '{6'b001000, 6'b001010};
    logic [31:0] rss  [2] = '{32'd10, 32'd3};
    logic [15:0] imms [2] = '{16'hFFFD, 16'd5};
    logic [31:0] dbs  [2] = '{32'hFFFF_FFFD, 32'd5};
    logic [31:0] ress [2] = '{32'd7, 32'd1};
    logic [2:0]  cons [2] = '{3'b000, 3'b100};
    for (int i = 0; i < 2; i++) begin
      int lat; logic rdy; exp_t e;
      sb.push_back('{res: ress[i], err: 1'b0, con: cons[i], lat: 2});
      send(ops[i], 6'b000000, rss[i], 32'h1234_5678, imms[i], lat, rdy);
      e = sb.pop_front();
      total_cnt++;
      if (lat !== e.lat) $display("FAIL imm%0d_latency: got %0d want %0d", i, lat, e.lat); else pass_cnt++;
      total_cnt++;
      if ({Result, ResErr, ALUCon, DataB} !== {e.res, e.err, e.con, dbs[i]})
        $display("FAIL imm%0d_result: got %h/%b/%b/%h want %h/%b/%b/%h", i, Result, ResErr, ALUCon, DataB,
                 e.res, e.err, e.con, dbs[i]);
      else pass_cnt++;
      release_res(0);
    end
  endtask

  task automatic test_mult;
    int lat; logic rdy; exp_t e;
    sb.push_back('{res: 32'd42, err: 1'b0, con: 3'b010, lat: 1 + MW + 1});
    send(6'b000000, 6'b011000, 32'd6, 32'd7, 16'd0, lat, rdy);
    e = sb.pop_front();
    total_cnt++;
    if (lat !== e.lat) $display("FAIL mult_latency: got %0d want %0d", lat, e.lat); else pass_cnt++;
    total_cnt++;
    if ({Result, ResErr, ALUCon} !== {e.res, e.err, e.con})
      $display("FAIL mult_result: got %h/%b/%b want %h/%b/%b", Result, ResErr, ALUCon, e.res, e.err, e.con);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total_cnt++;
      if ({ResValid, InstrReady, Result} !== {1'b1, 1'b0, e.res})
        $display("FAIL mult_hold%0d: got %b/%b/%h want 1/0/%h", i, ResValid, InstrReady, Result, e.res);
      else pass_cnt++;
    end
    release_res(0);
    @(negedge clk);
    total_cnt++;
    if ({ResValid, InstrReady} !== 2'b01) $display("FAIL mult_release: got %b want 01", {ResValid, InstrReady});
    else pass_cnt++;
  endtask

  task automatic test_illegal;
    int lat; logic rdy; exp_t e;
    // previous op was mult 6*7: ALU-facing outputs must not move
    sb.push_back('{res: 32'd0, err: 1'b1, con: 3'b010, lat: 1});
    send(6'b000000, 6'b100101, 32'd11, 32'd22, 16'd0, lat, rdy);
    e = sb.pop_front();
    total_cnt++;
    if (lat !== e.lat) $display("FAIL illegal_latency: got %0d want %0d", lat, e.lat); else pass_cnt++;
    total_cnt++;
    if ({Result, ResErr} !== {e.res, e.err})
      $display("FAIL illegal_result: got %h/%b want %h/%b", Result, ResErr, e.res, e.err);
    else pass_cnt++;
    total_cnt++;
    if ({ALUCon, DataA, DataB} !== {e.con, 32'd6, 32'd7})
      $display("FAIL illegal_hold: got %b/%h/%h want %b/6/7", ALUCon, DataA, DataB, e.con);
    else pass_cnt++;
    release_res(1);
    @(negedge clk);
    total_cnt++;
    if ({ResValid, ResErr, InstrReady} !== 3'b001)
      $display("FAIL illegal_release: got %b want 001", {ResValid, ResErr, InstrReady});
    else pass_cnt++;
  endtask

  task automatic test_div_zero;
    int lat; logic rdy; exp_t e;
`ifdef DIVZERO_CHK_EN
    sb.push_back('{res: 32'hFFFF_FFFF, err: 1'b1, con: 3'b011, lat: 1});
`else
    sb.push_back('{res: 32'h0BAD_0000, err: 1'b0, con: 3'b011, lat: 1 + MW + 1});
`endif
    send(6'b000000, 6'b011010, 32'd9, 32'd0, 16'd0, lat, rdy);
    e = sb.pop_front();
    total_cnt++;
    if (lat !== e.lat) $display("FAIL divz_latency: got %0d want %0d", lat, e.lat); else pass_cnt++;
    total_cnt++;
    if ({Result, ResErr} !== {e.res, e.err})
      $display("FAIL divz_result: got %h/%b want %h/%b", Result, ResErr, e.res, e.err);
    else pass_cnt++;
`ifndef DIVZERO_CHK_EN
    total_cnt++;
    if (ALUCon !== e.con) $display("FAIL divz_alucon: got %b want %b", ALUCon, e.con); else pass_cnt++;
`endif
    release_res(0);
  endtask

  // Valid held high continuously: accepts must be spaced by a full op
  task automatic test_back_to_back;
    int acc = 0;
    int res = 0;
    exp_t e;
    @(negedge clk);
    Opcode = 6'b000000; Funct = 6'b100000; RsData = 32'd1; RtData = 32'd2;
    InstrValid = 1'b1; ResReady = 1'b1;
    for (int c = 0; c < 9; c++) begin
      if (InstrReady === 1'b1) begin
        acc++;
        sb.push_back('{res: 32'd3, err: 1'b0, con: 3'b000, lat: 2});
      end
      if (ResValid === 1'b1 && sb.size() > 0) begin
        res++;
        e = sb.pop_front();
        total_cnt++;
        if (Result !== e.res) $display("FAIL b2b_result: got %h want %h", Result, e.res); else pass_cnt++;
      end
      @(negedge clk);
    end
    InstrValid = 1'b0; ResReady = 1'b0;
    total_cnt++;
    if (acc !== 3 || res !== 3) $display("FAIL b2b_count: got acc=%0d res=%0d want 3/3", acc, res);
    else pass_cnt++;
    sb.delete();
  endtask

  task automatic test_random;
    for (int n = 0; n < 8; n++) begin
      int lat; logic rdy; exp_t e;
      int k;
      logic [5:0] op, fn; logic [31:0] rs, rt, ex, se; logic [15:0] imm; logic [2:0] con;
      k = $urandom_range(6, 0);
      rs = $urandom; rt = $urandom; imm = 16'($urandom);
      se = {{16{imm[15]}}, imm};
      op = 6'b000000; fn = 6'b100000; con = 3'b000; ex = rs + rt;
      case (k)
        1: begin fn = 6'b100010; con = 3'b001; ex = rs - rt; end
        2: begin fn = 6'b101010; con = 3'b100; ex = {31'd0, rs < rt}; end
        3: begin op = 6'b001000; con = 3'b000; ex = rs + se; end
        4: begin op = 6'b001010; con = 3'b100; ex = {31'd0, rs < se}; end
        5: begin fn = 6'b011000; con = 3'b010; ex = rs * rt; end
        6: begin fn = 6'b011010; con = 3'b011; rt = $urandom_range(1000, 1); ex = rs / rt; end
        default: ;
      endcase
      sb.push_back('{res: ex, err: 1'b0, con: con, lat: (k >= 5) ? 1 + MW + 1 : 2});
      send(op, fn, rs, rt, imm, lat, rdy);
      e = sb.pop_front();
      total_cnt++;
      if (lat !== e.lat) $display("FAIL rand%0d_latency: got %0d want %0d", n, lat, e.lat); else pass_cnt++;
      total_cnt++;
      if ({Result, ResErr, ALUCon} !== {e.res, e.err, e.con})
        $display("FAIL rand%0d_result: got %h/%b/%b want %h/%b/%b", n, Result, ResErr, ALUCon, e.res, e.err, e.con);
      else pass_cnt++;
      release_res($urandom_range(2, 0));
    end
  endtask

  task automatic test_reset_mid_wait;
    int seen = 0;
    @(negedge clk);
    Opcode = 6'b000000; Funct = 6'b011000; RsData = 32'd6; RtData = 32'd7;
    InstrValid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    InstrValid = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({Busy, ResValid} !== 2'b10) $display("FAIL midwait_busy: got %b want 10", {Busy, ResValid});
    else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({InstrReady, ResValid, ResErr, Busy, ALUCon} !== 7'b1000_000)
      $display("FAIL midwait_reset_ctrl: got %b want 1000000", {InstrReady, ResValid, ResErr, Busy, ALUCon});
    else pass_cnt++;
    total_cnt++;
    if ({DataA, DataB, Result} !== 96'd0)
      $display("FAIL midwait_reset_data: got %h/%h/%h want 0", DataA, DataB, Result);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    ResReady = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (ResValid !== 1'b0) seen++;
    end
    ResReady = 1'b0;
    total_cnt++;
    if (seen !== 0) $display("FAIL midwait_discard: got %0d valid cycles want 0", seen); else pass_cnt++;
  endtask

  initial begin
    rst_n = 1'b0; InstrValid = 1'b0; ResReady = 1'b0;
    Opcode = '0; Funct = '0; RsData = '0; RtData = '0; Imm = '0;
    test_reset();
    test_add();
    test_addi_slti();
    test_mult();
    test_illegal();
    test_div_zero();
    test_back_to_back();
    test_random();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
